// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage that sits right after the PC register. It sends one
// instruction-memory request at a time, shows the fetched word to decode over
// a valid/ready handshake, and drives the PC register's next value and load
// enable. Only one memory request is ever outstanding. If a redirect arrives
// while a request is in flight, the response to that request is discarded.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   pc_in             current PC (output of the PC register)
//   pc_next, pc_en    next PC value and load enable for the PC register
//   imem_req_*        request channel to instruction memory (valid/ready/addr)
//   imem_rsp_*        in-order response channel (valid/data)
//   redirect_*        branch/jump/trap redirect from a later stage
//   if_valid/if_ready handshake with decode; if_pc/if_instr carry the payload
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter int XLEN    = 32,
    parameter int PC_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    output logic [XLEN-1:0] pc_next,
    output logic            pc_en,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t state;

    logic req_fire;
    logic busy_after;

    assign imem_req_valid = (state == S_REQ) && !rst;
    assign imem_req_addr  = pc_in;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // True when a memory request is still in flight at the end of this cycle.
    // A redirect uses this to decide whether the next response must be
    // thrown away.
    assign busy_after = req_fire ||
                        (((state == S_WAIT) || (state == S_DROP)) && !imem_rsp_valid);

    // A redirect takes priority over the sequential increment.
    assign pc_next = redirect_valid ? redirect_pc : (pc_in + XLEN'(PC_STEP));
    assign pc_en   = !rst && (redirect_valid || ((state == S_HOLD) && if_ready));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_REQ;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= '0;
        end else if (redirect_valid) begin
            if_valid <= 1'b0;
            state    <= busy_after ? S_DROP : S_REQ;
        end else begin
            unique case (state)
                S_REQ: begin
                    if (imem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if_instr <= imem_rsp_data;
                        if_pc    <= pc_in;
                        if_valid <= 1'b1;
                        state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (if_ready) begin
                        if_valid <= 1'b0;
                        state    <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rsp_valid) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule
